// File: rtl/rename_regfile_mp_pkg.sv
// rename_regfile_mp_pkg: sizes, word types and flat-bus slice helpers for the rename register file
package rename_regfile_mp_pkg;
  localparam int DATA_W  = 32;
  localparam int REG_CNT = 32;
  localparam int REG_W   = $clog2(REG_CNT);
  localparam int TAG_W   = 4;
  localparam int NUM_RD  = 4;
  localparam int NUM_CMT = 2;
  localparam int NUM_REN = 2;
  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [DATA_W-1:0] data_t;
  localparam tag_t TAG_FREE = {TAG_W{1'b1}};
  function automatic reg_t cmt_reg_at(input logic [NUM_CMT*REG_W-1:0] bus, input int i);
    return bus[i*REG_W +: REG_W];
  endfunction
  function automatic data_t cmt_data_at(input logic [NUM_CMT*DATA_W-1:0] bus, input int i);
    return bus[i*DATA_W +: DATA_W];
  endfunction
  function automatic tag_t cmt_tag_at(input logic [NUM_CMT*TAG_W-1:0] bus, input int i);
    return bus[i*TAG_W +: TAG_W];
  endfunction
  function automatic reg_t ren_reg_at(input logic [NUM_REN*REG_W-1:0] bus, input int i);
    return bus[i*REG_W +: REG_W];
  endfunction
  function automatic tag_t ren_tag_at(input logic [NUM_REN*TAG_W-1:0] bus, input int i);
    return bus[i*TAG_W +: TAG_W];
  endfunction
  function automatic reg_t rd_reg_at(input logic [NUM_RD*REG_W-1:0] bus, input int i);
    return bus[i*REG_W +: REG_W];
  endfunction
endpackage

// File: rtl/rename_regfile_mp_if.sv
// rename_regfile_mp_if: rename/commit/read bus between the core and the rename register file
interface rename_regfile_mp_if;
  import rename_regfile_mp_pkg::*;
  logic                      flush;
  logic [NUM_CMT-1:0]        cmt_en;
  logic [NUM_CMT*REG_W-1:0]  cmt_reg;
  logic [NUM_CMT*DATA_W-1:0] cmt_data;
  logic [NUM_CMT*TAG_W-1:0]  cmt_tag;
  logic [NUM_REN-1:0]        ren_en;
  logic [NUM_REN*REG_W-1:0]  ren_reg;
  logic [NUM_REN*TAG_W-1:0]  ren_tag;
  logic [NUM_RD*REG_W-1:0]   rd_reg;
  logic [NUM_RD*DATA_W-1:0]  rd_data;
  logic [NUM_RD*TAG_W-1:0]   rd_tag;
  modport master (output flush, cmt_en, cmt_reg, cmt_data, cmt_tag, ren_en, ren_reg, ren_tag, rd_reg,
                  input rd_data, rd_tag);
  modport slave (input flush, cmt_en, cmt_reg, cmt_data, cmt_tag, ren_en, ren_reg, ren_tag, rd_reg,
                 output rd_data, rd_tag);
endinterface

// File: rtl/rename_regfile_mp_read_bypass.sv
// rename_regfile_mp_read_bypass: one read port with same-cycle commit forwarding
module rename_regfile_mp_read_bypass
  import rename_regfile_mp_pkg::*;
(
  input  reg_t                      rd_reg_i,
  input  data_t [REG_CNT-1:0]       data_i,
  input  tag_t  [REG_CNT-1:0]       tag_i,
  input  logic  [NUM_CMT-1:0]       cmt_en_i,
  input  logic  [NUM_CMT*REG_W-1:0] cmt_reg_i,
  input  logic  [NUM_CMT*DATA_W-1:0] cmt_data_i,
  input  logic  [NUM_CMT*TAG_W-1:0] cmt_tag_i,
  output data_t                     rd_data_o,
  output tag_t                      rd_tag_o
);
  always_comb begin
    rd_data_o = data_i[rd_reg_i];
    rd_tag_o = tag_i[rd_reg_i];
    for (int c = 0; c < NUM_CMT; c++)
      if (cmt_en_i[c] && rd_reg_i != '0 && cmt_reg_at(cmt_reg_i, c) == rd_reg_i) begin
        rd_data_o = cmt_data_at(cmt_data_i, c);
        if (cmt_tag_at(cmt_tag_i, c) == tag_i[rd_reg_i]) rd_tag_o = TAG_FREE;
      end
  end
endmodule

// File: rtl/rename_regfile_mp.sv
// rename_regfile_mp: multi-port architectural register file with per-register rename tags
module rename_regfile_mp
  import rename_regfile_mp_pkg::*;
(
  input logic               clk,
  input logic               rst,
  rename_regfile_mp_if.slave bus
);
  data_t [REG_CNT-1:0] data_q, data_d;
  tag_t  [REG_CNT-1:0] tag_q, tag_d;
  // x0 is never updated, so its reset value of 0/TAG_FREE is permanent
  always_comb begin
    data_d = data_q;
    tag_d = tag_q;
    for (int r = 1; r < REG_CNT; r++) begin
      for (int c = 0; c < NUM_CMT; c++)
        if (bus.cmt_en[c] && cmt_reg_at(bus.cmt_reg, c) == reg_t'(r)) begin
          data_d[r] = cmt_data_at(bus.cmt_data, c);
          if (cmt_tag_at(bus.cmt_tag, c) == tag_q[r]) tag_d[r] = TAG_FREE;
        end
      if (bus.flush) tag_d[r] = TAG_FREE;
      else
        for (int n = 0; n < NUM_REN; n++)
          if (bus.ren_en[n] && ren_reg_at(bus.ren_reg, n) == reg_t'(r)) tag_d[r] = ren_tag_at(bus.ren_tag, n);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_q <= '0;
      tag_q <= {REG_CNT{TAG_FREE}};
    end else begin
      data_q <= data_d;
      tag_q <= tag_d;
    end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rename_regfile_mp_read_bypass u_rd (
      .rd_reg_i  (rd_reg_at(bus.rd_reg, i)),
      .data_i    (data_q),
      .tag_i     (tag_q),
      .cmt_en_i  (bus.cmt_en),
      .cmt_reg_i (bus.cmt_reg),
      .cmt_data_i(bus.cmt_data),
      .cmt_tag_i (bus.cmt_tag),
      .rd_data_o (bus.rd_data[i*DATA_W +: DATA_W]),
      .rd_tag_o  (bus.rd_tag[i*TAG_W +: TAG_W])
    );
  end
  for (genvar n = 0; n < NUM_REN; n++) begin : g_chk
    always @(posedge clk)
      if (!rst && bus.ren_en[n]) assert (ren_tag_at(bus.ren_tag, n) != TAG_FREE);
  end
endmodule
